// File: rtl/sub3_pkg.sv
// Shared definitions for the serial three-operand subtractor: FSM encoding,
// digit/borrow widths and the digit-count helper.
package sub3_pkg;

  localparam int DIG_W = 2;
  localparam int BRW_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of 2-bit digit steps needed to cover an n-bit operand.
  function automatic int digit_count(input int n);
    return (n + DIG_W - 1) / DIG_W;
  endfunction

endpackage

// File: rtl/sub3_digit.sv
// One radix-4 digit step of a - b - c - borrow.
// Purely combinational; the borrow can reach 2 because two subtrahends are folded in.
module sub3_digit
  import sub3_pkg::*;
(
  input  logic [DIG_W-1:0] a_dig,
  input  logic [DIG_W-1:0] b_dig,
  input  logic [DIG_W-1:0] c_dig,
  input  logic [BRW_W-1:0] brw_in,
  output logic [DIG_W-1:0] y_dig,
  output logic [BRW_W-1:0] brw_out
);

  // t = d + 8 keeps the signed digit difference (-8..3) in an unsigned 0..11 range.
  // The +8 offset is a multiple of 4, so the low bits are d mod 4 and the
  // upper bits are floor(d/4) + 2.
  logic [3:0] t;

  always_comb begin
    t       = 4'd8
            + {2'b00, a_dig}
            - {2'b00, b_dig}
            - {2'b00, c_dig}
            - {2'b00, brw_in};
    y_dig   = t[1:0];
    brw_out = 2'd2 - t[3:2];
  end

endmodule

// File: rtl/sub3_serial.sv
// Digit-serial (a - b - c) mod 2^N with underflow flag, one 2-bit digit per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module sub3_serial
  import sub3_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] y,
  output logic         underflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   dbg_state
);

  localparam int K  = digit_count(N);
  localparam int W  = K * DIG_W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     c_q, c_d;
  logic [W-1:0]     res_q, res_d;
  logic [BRW_W-1:0] brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             uf_q, uf_d;

  logic [DIG_W-1:0] dig_y;
  logic [BRW_W-1:0] dig_brw;

  sub3_digit u_digit (
    .a_dig   (a_q[DIG_W-1:0]),
    .b_dig   (b_q[DIG_W-1:0]),
    .c_dig   (c_q[DIG_W-1:0]),
    .brw_in  (brw_q),
    .y_dig   (dig_y),
    .brw_out (dig_brw)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    uf_d    = uf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = W'(a);
          b_d     = W'(b);
          c_d     = W'(c);
          brw_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Operands drain LSB digit first; result digits enter at the top so the
        // first digit ends up at bit 0 after K steps.
        a_d   = a_q >> DIG_W;
        b_d   = b_q >> DIG_W;
        c_d   = c_q >> DIG_W;
        res_d = (res_q >> DIG_W) | (W'(dig_y) << (W - DIG_W));
        brw_d = dig_brw;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          uf_d    = (dig_brw != '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      brw_q   <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = res_q[N-1:0];
  assign underflow = uf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub3_serial.sv
// Bench for sub3_serial: three lanes (N = 7, 8, 16) with directed cases, a
// mid-operation reset, and a randomized regression against an arithmetic model.
module tb_sub3_serial;

  localparam int NOPS = 3400;
  localparam int LIM  = 200;

  logic clk;
  logic rst_n;
  logic go_dir, go_abort, go_rand;
  int   done_cnt;
  int   n_cmp, n_err;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- lanes ----------------
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int NN = (g == 0) ? 7 : ((g == 1) ? 8 : 16);
    localparam int KK = (NN + 1) / 2;

    logic [NN-1:0] a, b, c, y;
    logic          in_valid, in_ready, underflow, out_valid, out_ready;
    logic [1:0]    dbg_state;
    logic [NN:0]   exp_q[$];
    logic [NN:0]   e;
    logic          snd_done;

    sub3_serial #(.N(NN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c         (c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .underflow (underflow),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
    );

    // Reference: plain integer subtraction, wrapped to NN bits.
    function automatic logic [NN:0] model(input logic [NN-1:0] aa, bb, cc);
      longint d, m;
      logic   uf;
      m  = longint'(1) << NN;
      d  = longint'(aa) - longint'(bb) - longint'(cc);
      uf = longint'(aa) < (longint'(bb) + longint'(cc));
      d  = d % m;
      if (d < 0) d = d + m;
      return {uf, NN'(d)};
    endfunction

    function automatic logic [NN-1:0] rnd_operand();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        default: return NN'($urandom);
      endcase
    endfunction

    task automatic chk(input string nm, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
        n_err++;
        $display("FAIL N=%0d %s: got %0d, expected %0d", NN, nm, got, want);
      end
    endtask

    // Called between clock edges; returns just after the accept edge.
    task automatic send(input logic [NN-1:0] aa, bb, cc);
      bit ok;
      ok = 0;
      a = aa; b = bb; c = cc; in_valid = 1'b1;
      for (int i = 0; i < LIM; i++) begin
        if (in_ready) begin
          exp_q.push_back(model(aa, bb, cc));
          @(posedge clk); #1;
          ok = 1;
          break;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL N=%0d accept timeout: in_ready never high in %0d cycles", NN, LIM);
      end
    endtask

    task automatic dir_op(input int ai, bi, ci, input int stall);
      int            lat;
      bit            busy_ok, hold_ok;
      logic [NN-1:0] y0;
      logic          u0;
      out_ready = 1'b0;
      send(NN'(ai), NN'(bi), NN'(ci));
      lat     = 1;
      busy_ok = 1;
      while (!out_valid && lat < LIM) begin
        if (in_ready) busy_ok = 0;
        @(posedge clk); #1;
        lat++;
      end
      chk("latency_edges", lat, KK + 1);
      chk("busy_in_ready_low", busy_ok, 1);
      chk("done_in_ready", in_ready, 0);
      y0 = y;
      u0 = underflow;
      if (stall > 0) begin
        hold_ok = 1;
        for (int i = 0; i < stall; i++) begin
          @(posedge clk); #1;
          if (!(out_valid && y == y0 && underflow == u0)) hold_ok = 0;
        end
        chk("hold_stable", hold_ok, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid_ready", {out_valid, in_ready}, 2'b01);
      chk("queue_empty_after_op", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL N=%0d spurious result: got y=%0d uf=%0b, expected no transfer",
                   NN, y, underflow);
        end else begin
          e = exp_q.pop_front();
          if ({underflow, y} !== e) begin
            n_err++;
            $display("FAIL N=%0d result: got y=%0d uf=%0b, expected y=%0d uf=%0b",
                     NN, y, underflow, e[NN-1:0], e[NN]);
          end
        end
      end
    end

    // ---------------- driver ----------------
    initial begin
      in_valid = 1'b0; out_ready = 1'b0; snd_done = 1'b0;
      a = '0; b = '0; c = '0;
      #3;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_y", y, 0);
      chk("reset_underflow", underflow, 0);
      chk("reset_state", dbg_state, 0);

      wait (go_dir);
      case (NN)
        8: begin
          dir_op(100, 30, 20, 0);
          dir_op(0, 255, 255, 1);
          dir_op(255, 0, 0, 0);
          dir_op(10, 3, 4, 3);
        end
        7: begin
          dir_op(127, 1, 1, 0);
          dir_op(1, 1, 1, 2);
        end
        default: begin
          dir_op(65535, 65535, 65535, 1);
          dir_op(0, 0, 0, 0);
          dir_op(40000, 20000, 19999, 0);
        end
      endcase
      done_cnt++;

      wait (go_abort);
      send(NN'(100), NN'(1), NN'(1));
      wait (rst_n === 1'b0);
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_state", dbg_state, 0);
      wait (rst_n === 1'b1);
      dir_op(9, 1, 1, 0);
      done_cnt++;

      wait (go_rand);
      fork
        begin
          for (int i = 0; i < NOPS; i++) begin
            repeat ($urandom_range(0, 1)) begin
              @(posedge clk); #1;
            end
            send(rnd_operand(), rnd_operand(), rnd_operand());
          end
          snd_done = 1'b1;
        end
        begin
          while (!snd_done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
      for (int i = 0; i < LIM && exp_q.size() > 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      chk("drain_queue_empty", exp_q.size(), 0);
      done_cnt++;
    end
  end

  // ---------------- sequencing and report ----------------
  task automatic wait_done(input string nm, input int lim);
    for (int i = 0; i < lim && done_cnt < 3; i++) @(posedge clk);
    n_cmp++;
    if (done_cnt < 3) begin
      n_err++;
      $display("FAIL %s phase timeout: got %0d lanes done, expected 3", nm, done_cnt);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0;
    go_dir = 1'b0; go_abort = 1'b0; go_rand = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    go_dir = 1'b1;
    wait_done("directed", 2000);

    done_cnt = 0;
    @(negedge clk);
    go_abort = 1'b1;
    @(posedge clk);            // accept edge
    @(posedge clk);            // first BUSY edge
    @(posedge clk);            // second BUSY edge
    #1 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_done("abort", 500);

    done_cnt = 0;
    go_rand = 1'b1;
    wait_done("random", 80000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub3_serial.md
SUB3_SERIAL -- requirements
Module: sub3_serial

Interface
REQ-001 Parameter N, default 8, operand and result width in bits, N >= 2.
REQ-002 Parameter K, derived as ceil(N/2); number of 2-bit digit cycles per operation; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  N  minuend, unsigned.
REQ-006 b  input  N  first subtrahend, unsigned.
REQ-007 c  input  N  second subtrahend, unsigned.
REQ-008 in_valid  input  1  a/b/c valid this cycle.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 y  output  N  result, (a - b - c) mod 2^N.
REQ-011 underflow  output  1  high when a < b + c as unbounded unsigned integers.
REQ-012 out_valid  output  1  y/underflow valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); both are decoded from registered state only.
REQ-016 In IDLE, the block SHALL capture a, b and c on an edge with in_valid && in_ready. Odd N operands are zero-extended to 2K bits. The borrow register is cleared, the digit counter is cleared, and the FSM moves to BUSY.
REQ-017 In BUSY, each edge SHALL process one 2-bit digit, LSB digit first:
- d = a_dig - b_dig - c_dig - borrow, range -8..3.
- result digit = d mod 4.
- new borrow = ceil(-d/4), range 0..2, held in a 2-bit register.
REQ-018 After the K-th BUSY edge, the FSM SHALL enter DONE. Latency is K+1 edges from the accept edge to out_valid high; for N=8, that is 5.
REQ-019 In DONE, y SHALL be the low N result bits and underflow SHALL be (final borrow != 0). Both are held stable until the handshake completes.
REQ-020 The FSM SHALL leave DONE for IDLE on an edge with out_valid && out_ready; otherwise it stays in DONE indefinitely.
REQ-021 The block SHALL NOT overlap operations; in_valid is ignored outside IDLE, and operand registers do not change outside the accept edge.
REQ-022 Result registers SHALL update only during BUSY; y and underflow are don't-care outside DONE but must never be X after reset.
REQ-023 A result SHALL be identical to the combinational reference (a - b - c) for every operand value, including all-zeros and all-ones.

Reset
REQ-024 While rst_n is low, the block SHALL immediately force:
- state = IDLE, so in_ready = 1 and out_valid = 0.
- y = 0, underflow = 0.
- borrow = 0, counter = 0, operand registers = 0.
REQ-025 Reset asserted in BUSY or DONE SHALL abandon the operation with no result delivered. The first edge after rst_n rises may accept new operands.

Structure
REQ-026 The shared package sub3_pkg SHALL hold:
- state encodings IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
- digit width constant DIG_W = 2;
- borrow width constant BRW_W = 2.
REQ-027 The digit arithmetic SHALL be one purely combinational sub-module, sub3_digit. Inputs: 2-bit a/b/c digits and 2-bit borrow in. Outputs: 2-bit digit and 2-bit borrow out.
REQ-028 Operands SHALL sit in shift registers that shift right by 2 each BUSY edge. Result digits are shifted in from the MSB end.

Verification
REQ-029 N=8, a=100, b=30, c=20, out_ready=1 -> y=50, underflow=0, out_valid high exactly 5 edges after accept, in_ready low for those 5 cycles.
REQ-030 N=8, a=0, b=255, c=255 -> y=2, underflow=1 (final borrow=2); a=255, b=0, c=0 -> y=255, underflow=0.
REQ-031 N=8, a=10, b=3, c=4, out_ready held low 3 cycles after out_valid -> y=3 stable throughout, single transfer, then in_ready=1 on the next cycle.
REQ-032 N=8, rst_n pulsed low on the 2nd BUSY edge -> out_valid=0 and in_ready=1 at once, with no spurious result. A following a=9, b=1, c=1 -> y=7.
REQ-033 N=7, a=127, b=1, c=1 -> y=125, underflow=0, latency 5 edges (K=4). Then a=1, b=1, c=1 -> y=127, underflow=1.
REQ-034 Random regression of at least 10k operations, N in {7, 8, 16}, random in_valid/out_ready -> every y and underflow matches the reference, with no lost or duplicated results.
